regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 156 +++++++++++++++
 tb/tb_regfile_writeback.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file writeback unit: 2-entry ALU/load queue, unaligned word split, hazard detect
module regfile_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic        alu_word,
    input  logic [5:0]  alu_d,
    input  logic [15:0] alu_Rd,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [5:0]  mem_d,
    input  logic [7:0]  mem_Rd,
    output logic        write,
    output logic        write_word,
    output logic [5:0]  d,
    output logic [15:0] Rd,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    input  logic        a_word,
    output logic        hazard,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, SPLIT_HI} state_t;

    state_t      r_state;
    logic [5:0]  r_fd [2];
    logic [15:0] r_frd [2];
    logic [1:0]  r_fword;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_run;
    logic [5:0]  r_split_d;
    logic [7:0]  r_split_hi;
    logic        r_write;
    logic        r_write_word;
    logic [5:0]  r_d;
    logic [15:0] r_rd;

    logic        w_pop, w_full, w_push_mem, w_push_alu, w_push;
    logic [5:0]  w_in_d, w_hd;
    logic [15:0] w_in_rd, w_hrd;
    logic        w_in_word, w_hword;
    logic [1:0]  w_count_next;
    logic [1:0]  w_slot_valid;
    logic        w_hazard;

    // Read set of the decode stage: a (or pair a,a+1) and b.
    function automatic logic f_hits(input logic [5:0] x, input logic [5:0] ra,
                                    input logic [5:0] rb, input logic rw);
        logic [5:0] ra1;
        ra1 = ra + 6'd1;
        return (x == ra) || (rw && (x == ra1)) || (x == rb);
    endfunction

    // The head is never popped while the high half of a split word is still pending.
    assign w_pop      = (r_state != SPLIT_HI) && (r_count != 2'd0);
    assign w_full     = (r_count == 2'd2) && !w_pop;
    assign mem_ready  = r_run && !w_full;
    assign alu_ready  = r_run && !w_full && !mem_valid;
    assign w_push_mem = mem_valid && mem_ready;
    assign w_push_alu = alu_valid && alu_ready;
    assign w_push     = w_push_mem || w_push_alu;
    assign w_in_d     = w_push_mem ? mem_d : alu_d;
    assign w_in_rd    = w_push_mem ? {8'h00, mem_Rd} : alu_Rd;
    assign w_in_word  = w_push_mem ? 1'b0 : alu_word;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_hd       = r_fd[r_rd_ptr];
    assign w_hrd      = r_frd[r_rd_ptr];
    assign w_hword    = r_fword[r_rd_ptr];

    assign w_slot_valid[0] = (r_count == 2'd2) || ((r_count == 2'd1) && !r_rd_ptr);
    assign w_slot_valid[1] = (r_count == 2'd2) || ((r_count == 2'd1) && r_rd_ptr);

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (w_slot_valid[i] && (f_hits(r_fd[i], a, b, a_word) ||
                (r_fword[i] && f_hits(r_fd[i] + 6'd1, a, b, a_word))))
                w_hazard = 1'b1;
        end
        if ((r_state == SPLIT_HI) && f_hits(r_split_d, a, b, a_word))
            w_hazard = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_fd[0]  <= 6'd0;
            r_fd[1]  <= 6'd0;
            r_frd[0] <= 16'd0;
            r_frd[1] <= 16'd0;
            r_fword  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fd[r_wr_ptr]    <= w_in_d;
                r_frd[r_wr_ptr]   <= w_in_rd;
                r_fword[r_wr_ptr] <= w_in_word;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_run        <= 1'b0;
            r_split_d    <= 6'd0;
            r_split_hi   <= 8'd0;
            r_write      <= 1'b0;
            r_write_word <= 1'b0;
            r_d          <= 6'd0;
            r_rd         <= 16'd0;
        end else begin
            r_run <= 1'b1;
            if (r_state == SPLIT_HI) begin
                r_write      <= 1'b1;
                r_write_word <= 1'b0;
                r_d          <= r_split_d;
                r_rd         <= {8'h00, r_split_hi};
                r_state      <= (w_count_next != 2'd0) ? ISSUE : IDLE;
            end else if (w_pop) begin
                r_write <= 1'b1;
                r_d     <= w_hd;
                if (w_hword && w_hd[0]) begin
                    r_write_word <= 1'b0;
                    r_rd         <= {8'h00, w_hrd[7:0]};
                    r_split_d    <= w_hd + 6'd1;
                    r_split_hi   <= w_hrd[15:8];
                    r_state      <= SPLIT_HI;
                end else begin
                    r_write_word <= w_hword;
                    r_rd         <= w_hrd;
                    r_state      <= (w_count_next != 2'd0) ? ISSUE : IDLE;
                end
            end else begin
                r_write      <= 1'b0;
                r_write_word <= 1'b0;
                r_state      <= (w_count_next != 2'd0) ? ISSUE : IDLE;
            end
        end
    end

    assign write      = r_write;
    assign write_word = r_write_word;
    assign d          = r_d;
    assign Rd         = r_rd;
    assign hazard     = w_hazard;
    assign busy       = (r_count != 2'd0) || (r_state == SPLIT_HI);
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed vector bench for regfile_writeback
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, alu_word;
    logic [5:0]  alu_d;
    logic [15:0] alu_Rd;
    logic        mem_valid, mem_ready;
    logic [5:0]  mem_d;
    logic [7:0]  mem_Rd;
    logic        write, write_word;
    logic [5:0]  d;
    logic [15:0] Rd;
    logic [5:0]  a, b;
    logic        a_word;
    logic        hazard, busy;

    int checks = 0;
    int errors = 0;

    regfile_writeback dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_word(alu_word),
        .alu_d(alu_d), .alu_Rd(alu_Rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_d(mem_d), .mem_Rd(mem_Rd),
        .write(write), .write_word(write_word), .d(d), .Rd(Rd),
        .a(a), .b(b), .a_word(a_word), .hazard(hazard), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_mem;
        logic        word;
        logic [5:0]  dst;
        logic [15:0] data;
        int          n;
        logic        ww;
        logic [5:0]  d0;
        logic [15:0] r0;
        logic [5:0]  d1;
        logic [15:0] r1;
    } vec_t;

    typedef struct {
        logic        word;
        logic [5:0]  dst;
        logic [15:0] data;
    } push_t;

    typedef struct {
        logic [5:0]  dd;
        logic [15:0] rr;
        logic        ww;
    } wr_t;

    vec_t  vecs [7];
    push_t pq [$];
    wr_t   eq [$];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 6'd5,  16'h00A7, 1, 1'b0, 6'd5,  16'h00A7, 6'd0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 6'd24, 16'h1234, 1, 1'b1, 6'd24, 16'h1234, 6'd0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 6'd63, 16'hBEEF, 2, 1'b0, 6'd63, 16'h00EF, 6'd0, 16'h00BE};
        vecs[3] = '{1'b1, 1'b0, 6'd9,  16'h005C, 1, 1'b0, 6'd9,  16'h005C, 6'd0, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 6'd1,  16'hABCD, 2, 1'b0, 6'd1,  16'h00CD, 6'd2, 16'h00AB};
        vecs[5] = '{1'b0, 1'b0, 6'd62, 16'h1234, 1, 1'b0, 6'd62, 16'h1234, 6'd0, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 6'd0,  16'hFFFF, 1, 1'b1, 6'd0,  16'hFFFF, 6'd0, 16'h0000};

        reset = 1'b0;
        alu_valid = 1'b0; alu_word = 1'b0; alu_d = 6'd0; alu_Rd = 16'd0;
        mem_valid = 1'b0; mem_d = 6'd0; mem_Rd = 8'd0;
        a = 6'd40; b = 6'd41; a_word = 1'b0;

        tick;
        tick;
        chk("rst_write", write, 0);
        chk("rst_write_word", write_word, 0);
        chk("rst_d", d, 0);
        chk("rst_Rd", Rd, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        #2 reset = 1'b1;
        #1 chk("ready_before_edge", alu_ready, 0);
        tick;
        chk("alu_ready_after_edge", alu_ready, 1);
        chk("mem_ready_after_edge", mem_ready, 1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_mem) begin
                mem_valid = 1'b1; mem_d = vecs[i].dst; mem_Rd = vecs[i].data[7:0];
            end else begin
                alu_valid = 1'b1; alu_word = vecs[i].word;
                alu_d = vecs[i].dst; alu_Rd = vecs[i].data;
            end
            #1;
            chk($sformatf("v%0d_ready", i), vecs[i].is_mem ? mem_ready : alu_ready, 1);
            tick;
            alu_valid = 1'b0; mem_valid = 1'b0;
            chk($sformatf("v%0d_latency_write", i), write, 0);
            chk($sformatf("v%0d_busy", i), busy, 1);
            tick;
            chk($sformatf("v%0d_write0", i), write, 1);
            chk($sformatf("v%0d_ww0", i), write_word, vecs[i].ww);
            chk($sformatf("v%0d_d0", i), d, vecs[i].d0);
            chk($sformatf("v%0d_Rd0", i), Rd, vecs[i].r0);
            if (vecs[i].n == 2) begin
                tick;
                chk($sformatf("v%0d_write1", i), write, 1);
                chk($sformatf("v%0d_ww1", i), write_word, 0);
                chk($sformatf("v%0d_d1", i), d, vecs[i].d1);
                chk($sformatf("v%0d_Rd1", i), Rd, vecs[i].r1);
            end
            tick;
            chk($sformatf("v%0d_write_end", i), write, 0);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
        end

        // unaligned word to 63 wraps into register 0; b=0 sees the pending high half
        b = 6'd0;
        alu_valid = 1'b1; alu_word = 1'b1; alu_d = 6'd63; alu_Rd = 16'hBEEF;
        tick;
        alu_valid = 1'b0;
        chk("haz63_queued", hazard, 1);
        tick;
        chk("haz63_split_pending", hazard, 1);
        b = 6'd40; a = 6'd62; a_word = 1'b1;
        #1 chk("haz63_output_not_hazard", hazard, 0);
        b = 6'd0; a = 6'd40; a_word = 1'b0;
        tick;
        chk("haz63_done_d", d, 0);
        chk("haz63_done", hazard, 0);
        b = 6'd41;
        tick;

        alu_valid = 1'b1; alu_word = 1'b1; alu_d = 6'd16; alu_Rd = 16'h5A5A;
        tick;
        alu_valid = 1'b0;
        b = 6'd40; a = 6'd17; a_word = 1'b0;
        #1 chk("haz16_a17", hazard, 1);
        a = 6'd14; a_word = 1'b1;
        #1 chk("haz16_a14w", hazard, 0);
        a = 6'd15; a_word = 1'b1;
        #1 chk("haz16_a15w", hazard, 1);
        a = 6'd40; a_word = 1'b0; b = 6'd17;
        #1 chk("haz16_b17", hazard, 1);
        b = 6'd41;
        #1 chk("haz16_none", hazard, 0);
        tick;
        tick;
        chk("haz16_idle", busy, 0);

        // simultaneous sources: mem wins
        mem_valid = 1'b1; mem_d = 6'd20; mem_Rd = 8'h99;
        alu_valid = 1'b1; alu_word = 1'b0; alu_d = 6'd21; alu_Rd = 16'h7777;
        #1;
        chk("prio_alu_ready", alu_ready, 0);
        chk("prio_mem_ready", mem_ready, 1);
        tick;
        mem_valid = 1'b0;
        #1 chk("prio_alu_ready_after", alu_ready, 1);
        tick;
        alu_valid = 1'b0;
        chk("prio_first_d", d, 20);
        chk("prio_first_Rd", Rd, 16'h0099);
        tick;
        chk("prio_second_d", d, 21);
        chk("prio_second_Rd", Rd, 16'h7777);
        tick;

        // back-to-back pushes with split words to fill the queue
        begin
            logic saw_full;
            logic acc;
            saw_full = 1'b0;
            pq.push_back('{1'b1, 6'd1, 16'hA1B1});
            pq.push_back('{1'b1, 6'd3, 16'hC2D2});
            pq.push_back('{1'b1, 6'd5, 16'hE3F3});
            pq.push_back('{1'b0, 6'd7, 16'h0044});
            pq.push_back('{1'b0, 6'd9, 16'h0055});
            eq.push_back('{6'd1, 16'h00B1, 1'b0});
            eq.push_back('{6'd2, 16'h00A1, 1'b0});
            eq.push_back('{6'd3, 16'h00D2, 1'b0});
            eq.push_back('{6'd4, 16'h00C2, 1'b0});
            eq.push_back('{6'd5, 16'h00F3, 1'b0});
            eq.push_back('{6'd6, 16'h00E3, 1'b0});
            eq.push_back('{6'd7, 16'h0044, 1'b0});
            eq.push_back('{6'd9, 16'h0055, 1'b0});
            for (int cyc = 0; cyc < 40 && (pq.size() > 0 || eq.size() > 0); cyc++) begin
                if (pq.size() > 0) begin
                    alu_valid = 1'b1; alu_word = pq[0].word;
                    alu_d = pq[0].dst; alu_Rd = pq[0].data;
                end else begin
                    alu_valid = 1'b0;
                end
                #1;
                if (alu_valid && !alu_ready && !mem_ready) saw_full = 1'b1;
                acc = alu_valid && alu_ready;
                tick;
                if (acc) void'(pq.pop_front());
                if (write) begin
                    if (eq.size() == 0) begin
                        chk("fill_extra_write", write, 0);
                    end else begin
                        chk("fill_d", d, eq[0].dd);
                        chk("fill_Rd", Rd, eq[0].rr);
                        chk("fill_ww", write_word, eq[0].ww);
                        void'(eq.pop_front());
                    end
                end
            end
            alu_valid = 1'b0;
            chk("fill_saw_full", saw_full, 1);
            chk("fill_all_pushed", pq.size(), 0);
            chk("fill_all_written", eq.size(), 0);
        end
        tick;
        tick;
        chk("fill_idle", busy, 0);

        // reset between issues
        alu_valid = 1'b1; alu_word = 1'b0; alu_d = 6'd10; alu_Rd = 16'h0101;
        tick;
        alu_d = 6'd11; alu_Rd = 16'h0202;
        tick;
        alu_valid = 1'b0;
        chk("rstmid_first_write", write, 1);
        chk("rstmid_first_d", d, 10);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_write", write, 0);
        chk("rstmid_d", d, 0);
        chk("rstmid_Rd", Rd, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", mem_ready, 0);
        tick;
        tick;
        reset = 1'b1;
        begin
            int nw;
            nw = 0;
            for (int i = 0; i < 6; i++) begin
                tick;
                if (write) nw++;
            end
            chk("rstmid_no_write_after", nw, 0);
            chk("rstmid_idle_after", busy, 0);
            chk("rstmid_ready_after", alu_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
